serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial ripple adder: one full-adder cell plus a carry flip-flop, iterated
//  over WIDTH clocks. Sits downstream of the 1-bit full-adder cell and consumes
//  its sum/carry each cycle. Trades WIDTH cycles of latency for one-bit datapath area.
//  Used wherever a multi-bit add is needed and throughput is not critical.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk    in   1      system clock; all state updates on the rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE or DONE
//  a      in   WIDTH  operand A; captured on the accepting edge
//  b      in   WIDTH  operand B; captured on the accepting edge
//  cin    in   1      carry-in; captured on the accepting edge
//  busy   out  1      high while in RUN
//  done   out  1      one-cycle pulse; sum/cout valid
//  sum    out  WIDTH  result; held until the next completion
//  cout   out  1      final carry-out; held with sum
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (rst).
//  - rst=1 at an edge: state=IDLE and busy=done=cout=0.
//    It also clears sum, the shift registers, the carry flop and the bit counter.
//  - rst overrides everything, including mid-RUN. The partial result is discarded.
//  - FSM states: IDLE, RUN, DONE.
//    - IDLE with start=1: go to RUN. Capture a and b into shift regs, carry<=cin, cnt<=0.
//    - RUN on every edge: s=a0^b0^c, c<=(a0&b0)|(b0&c)|(c&a0).
//      Shift a and b right, shift s into the result reg MSB, cnt<=cnt+1.
//    - RUN when cnt==WIDTH-1: go to DONE. sum<=final shifted result, cout<=final carry.
//    - DONE: done=1 for exactly one cycle.
//      Next state is RUN if start=1 (back-to-back, same capture as IDLE), else IDLE.
//  - Latency: if start is accepted at edge E0, done=1 in the cycle after edge E0+WIDTH.
//    Throughput is one add per WIDTH+1 cycles.
//  - start during RUN is ignored (not queued). Operand changes during RUN have no effect.
//  - sum and cout change only on the RUN->DONE edge or on reset.
//  - Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Result is unsigned.
//  - cnt is $clog2(WIDTH) bits wide and never wraps inside RUN.
//  - busy and done are never high together.
// CONFIGURATION
//  - Macro SERIAL_ADDER_OVF_EN.
//  - Defined: adds port `ovf out 1` (signed two's-complement overflow).
//    ovf = carry into the MSB XOR final carry-out, registered with sum.
//    ovf resets to 0 and is held like sum.
//  - Undefined: the ovf port and its carry-into-MSB flop are absent. All other behaviour is identical.
// TESTING (WIDTH=8)
//  1. Basic add: a=0x5A, b=0x3C, cin=0, start for 1 cycle.
//     -> busy for 8 cycles, then done pulse; sum=0x96, cout=0, ovf=1 (if enabled).
//  2. Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0.
//     a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
//  3. Ignore and hold: start pulses and operand changes mid-RUN
//     -> result equals the first captured operands.
//     No second done pulse. sum is unchanged until the next completion.
//  4. Reset mid-op: rst=1 at cnt=4
//     -> next cycle state=IDLE, busy=0, done=0, sum=0x00, cout=0.
//     No done pulse follows.
//  5. Back-to-back: start held high, ops 0x01+0x01 then 0x80+0x80
//     -> done pulses 9 cycles apart; sums 0x02/cout0 then 0x00/cout1.
//  6. Reset/idle: after rst with start=0
//     -> busy=0, done=0, sum=0 indefinitely.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder.
// One full-adder cell plus a carry flop, iterated over WIDTH clocks.
// {cout_o, sum_o} = a_i + b_i + cin_i, unsigned, modulo 2^(WIDTH+1).
// Optional build macro SERIAL_ADDER_OVF_EN adds ovf_o, the signed
// two's-complement overflow flag registered alongside sum_o.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start_i; result registers hold the last answer
// S_RUN  | one operand bit pair consumed per clock, LSB first
// S_DONE | done_o pulses for this cycle; start_i here chains a new add
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-adder cell working on the current LSBs and the carry flop.
  logic bit_s;
  logic carry_nxt;
  assign bit_s     = a_q[0] ^ b_q[0] ^ c_q;
  assign carry_nxt = (a_q[0] & b_q[0]) | (b_q[0] & c_q) | (c_q & a_q[0]);

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state, datapath update and status outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    busy_o  = 1'b0;
    done_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          a_d     = a_i;
          b_d     = b_i;
          c_d     = cin_i;
          cnt_d   = '0;
          res_d   = '0;
        end
      end

      S_RUN: begin
        busy_o = 1'b1;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        c_d    = carry_nxt;
        res_d  = {bit_s, res_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the result. cnt is reloaded on the next
          // capture, so it never needs to wrap here.
          state_d = S_DONE;
          cnt_d   = cnt_q;
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB on this final step.
          ovf_d   = c_q ^ carry_nxt;
`endif
        end
      end

      S_DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          state_d = S_RUN;
          a_d     = a_i;
          b_d     = b_i;
          c_d     = cin_i;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed checks of serial_adder against
// a plain-arithmetic reference model. Honours SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a_in),
    .b_i     (b_in),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf_o   (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned add plus signed-overflow rule on the operand signs.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec,
                              input logic eo);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: undefined ovf expectation");
`endif
  endtask

  // Tick until done is seen or the budget runs out; optionally wiggle
  // start and operands while the add is in flight.
  task automatic wait_done(input bit scramble, output int lat, output bit overlap);
    lat     = 0;
    overlap = 1'b0;
    while (!done && lat < 4 * W) begin
      if (busy && done) overlap = 1'b1;
      if (scramble) begin
        start = 1'($urandom_range(0, 1));
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        cin   = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input bit scramble);
    logic [W-1:0] es;
    logic         ec, eo;
    int           lat;
    bit           overlap;
    bit           extra_done;
    bit           moved;
    model(a, b, c, es, ec, eo);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_run"}, busy, 1'b1);
    wait_done(scramble, lat, overlap);
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(W));
    chk({tag, "_overlap"}, overlap, 1'b0);
    check_result(tag, es, ec, eo);
    extra_done = 1'b0;
    moved      = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      if (scramble) begin
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
      tick();
      if (done || busy) extra_done = 1'b1;
      if (sum !== es || cout !== ec) moved = 1'b1;
    end
    chk({tag, "_single_done"}, extra_done, 1'b0);
    chk({tag, "_held"}, moved, 1'b0);
  endtask

  // Two adds with start held high across the DONE cycle.
  task automatic b2b(input string tag, input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic c0, input logic [W-1:0] a1, input logic [W-1:0] b1,
                     input logic c1);
    logic [W-1:0] es0, es1;
    logic         ec0, ec1, eo0, eo1;
    int           lat;
    bit           overlap;
    model(a0, b0, c0, es0, ec0, eo0);
    model(a1, b1, c1, es1, ec1, eo1);
    a_in  = a0;
    b_in  = b0;
    cin   = c0;
    start = 1'b1;
    tick();
    a_in = a1;
    b_in = b1;
    cin  = c1;
    wait_done(1'b0, lat, overlap);
    chk({tag, "_lat0"}, 64'(lat), 64'(W));
    check_result({tag, "_op0"}, es0, ec0, eo0);
    tick();
    chk({tag, "_rerun_busy"}, busy, 1'b1);
    chk({tag, "_rerun_done"}, done, 1'b0);
    wait_done(1'b0, lat, overlap);
    start = 1'b0;
    chk({tag, "_spacing"}, 64'(lat + 1), 64'(W + 1));
    check_result({tag, "_op1"}, es1, ec1, eo1);
    tick();
    chk({tag, "_idle"}, busy | done, 1'b0);
  endtask

  initial begin
    bit any_act;
    bit nonzero;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    rst = 1'b0;
    tick();

    do_op("basic", 8'h5A, 8'h3C, 1'b0, 1'b0);
    do_op("carry1", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("carry2", 8'hFF, 8'hFF, 1'b1, 1'b0);
    do_op("ignore", 8'h37, 8'hC4, 1'b1, 1'b1);

    // Reset while cnt==4; the partial add must vanish without a done pulse.
    a_in  = 8'h6B;
    b_in  = 8'h29;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_sum", sum, '0);
    chk("midrst_cout", cout, 1'b0);
    any_act = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (done || busy) any_act = 1'b1;
    end
    chk("midrst_no_done", any_act, 1'b0);

    b2b("b2b", 8'h01, 8'h01, 1'b0, 8'h80, 8'h80, 1'b0);

    for (int k = 0; k < 30; k++) begin
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    for (int k = 0; k < 6; k++) begin
      b2b("rand_b2b", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
          W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    // Quiet after reset with start low.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    any_act = 1'b0;
    nonzero = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      a_in = W'($urandom);
      b_in = W'($urandom);
      tick();
      if (busy || done) any_act = 1'b1;
      if (sum !== '0 || cout !== 1'b0) nonzero = 1'b1;
    end
    chk("idle_quiet", any_act, 1'b0);
    chk("idle_sum_zero", nonzero, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
